mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op, input, 7 bits: opcode from the instruction register.
REQ-004 SHALL have port funct3, input, 3 bits: instr[14:12].
REQ-005 SHALL have port funct7, input, 1 bit: instr[30].
REQ-006 SHALL have ports ZF and SF, inputs, 1 bit each: ALU zero flag and sign flag, used combinationally.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access completes in the cycle where it is high.
REQ-008 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite, MemRead and AdrSrc, outputs, 1 bit each; AdrSrc 0 selects PC, 1 selects ALUOut.
REQ-009 SHALL have port ALUSrcA, output, 2 bits: 00 PC, 01 OldPC, 10 rs1 register A.
REQ-010 SHALL have port ALUSrcB, output, 2 bits: 00 rs2 register B, 01 immediate, 10 constant 4.
REQ-011 SHALL have port ResultSrc, output, 2 bits: 00 ALUOut, 01 memory data, 10 ALUResult.
REQ-012 SHALL have port ImmSrc, output, 2 bits: 00 I-type, 01 S-type, 10 B-type.
REQ-013 SHALL have port ALUControl, output, 3 bits: 000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
REQ-014 SHALL have port illegal, output, 1 bit: sticky unsupported-opcode flag.
REQ-015 SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-016 SHALL use these state encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, ILLEGAL 10.
REQ-017 SHALL drive all outputs combinationally from state, with PCWrite and IRWrite also gated by mem_ready, ZF and SF; any output not listed for a state SHALL be 0.
REQ-018 In FETCH it SHALL drive MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, and IRWrite=PCWrite=mem_ready.
REQ-019 SHALL hold FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-020 In DECODE it SHALL drive ALUSrcA=01, ALUSrcB=01, ALUControl=000 (branch target into ALUOut).
REQ-021 In DECODE it SHALL drive ImmSrc from op: 0100011 gives 01, 1100011 gives 10, all other opcodes give 00.
REQ-022 From DECODE it SHALL go to MEMADR for op 0000011 or 0100011, EXECR for 0110011, EXECI for 0010011, BRANCH for 1100011, and ILLEGAL for any other opcode.
REQ-023 In MEMADR it SHALL drive ALUSrcA=10, ALUSrcB=01, ALUControl=000, with ImmSrc per REQ-021, then go to MEMREAD if op[5]=0, else MEMWRITE.
REQ-024 In MEMREAD it SHALL drive MemRead=1, AdrSrc=1, hold while mem_ready=0, and go to MEMWB on mem_ready=1.
REQ-025 In MEMWB it SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-026 In MEMWRITE it SHALL drive MemWrite=1, AdrSrc=1, ImmSrc=01, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-027 In EXECR it SHALL drive ALUSrcA=10 and ALUSrcB=00; in EXECI it SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=00; both SHALL go to ALUWB.
REQ-028 In EXECR and EXECI, ALUControl SHALL follow funct3: 000 gives add, or sub only when funct7=1 and op[5]=1 (R-type); 001, 100, 101, 110 and 111 give their own codes; any other funct3 gives 000.
REQ-029 In ALUWB it SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-030 In BRANCH it SHALL drive ALUSrcA=10, ALUSrcB=00, ALUControl=010, ResultSrc=00, then go to FETCH.
REQ-031 In BRANCH it SHALL drive PCWrite = ZF for funct3 000, ~ZF for 001, SF for 100, and 0 for any other funct3.
REQ-032 ILLEGAL SHALL be terminal until reset, with illegal=1 and all other outputs 0.
REQ-033 SHALL assert MemWrite and RegWrite in disjoint states only; MemWrite and MemRead SHALL never both be 1.

Reset
REQ-034 While rst_n=0, the block SHALL be in FETCH (state=0) and illegal SHALL be 0, immediately and without waiting for a clock edge.
REQ-035 While rst_n=0, every write strobe (PCWrite, IRWrite, RegWrite, MemWrite) SHALL be 0 regardless of mem_ready.
REQ-036 Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction with no further strobes.
REQ-037 After rst_n rises, the first transition SHALL occur on the first rising clk edge.

Verification
REQ-038 Bench SHALL cover lw with 2 wait cycles: op=0000011, mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; RegWrite=1 only in MEMWB.
REQ-039 Bench SHALL cover sw: op=0100011 -> states 0,1,2,5,0; MemWrite=1 only in state 5 with AdrSrc=1 and ImmSrc=01.
REQ-040 Bench SHALL cover R-type sub: op=0110011, funct3=000, funct7=1 -> ALUControl=010 in EXECR; the same fields with op=0010011 -> ALUControl=000.
REQ-041 Bench SHALL cover branches: beq with ZF=1 -> PCWrite=1 in BRANCH; bne with ZF=1 -> PCWrite=0; blt with SF=1 -> PCWrite=1; funct3=010 -> PCWrite=0.
REQ-042 Bench SHALL cover illegal opcode: op=1111111 -> state 10 with illegal=1, held for 5 or more cycles until rst_n=0, then state 0.
REQ-043 Bench SHALL cover async reset: rst_n driven low between clock edges while in MEMREAD -> state=0 and all strobes 0 before the next edge.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath: decode
// fields, ALU flags and the memory handshake in; control strobes and selects out.
interface mc_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       ZF;
    logic       SF;
    // mem_ready is the completion half of the memory handshake: a request
    // (MemRead/MemWrite) is held steady and completes in the cycle mem_ready=1.
    logic       mem_ready;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7, ZF, SF, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, state
    );

    modport slave (
        output op, funct3, funct7, ZF, SF, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32 subset controller: Moore state machine with flag/handshake
// gated PC and IR write enables.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_ILLEGAL  = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0] state_d, state_q;
    logic [1:0] imm_dec;
    logic [2:0] alu_dec;
    logic       branch_taken;
    logic       pc_write, ir_write, reg_write, mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        imm_dec = 2'b00;
        if (bus.op == OP_STORE)       imm_dec = 2'b01;
        else if (bus.op == OP_BRANCH) imm_dec = 2'b10;
    end

    // Subtract only for R-type with funct7 set; I-type addi never subtracts.
    always_comb begin
        alu_dec = 3'b000;
        case (bus.funct3)
            3'b000:  alu_dec = (bus.funct7 && bus.op[5]) ? 3'b010 : 3'b000;
            3'b001:  alu_dec = 3'b001;
            3'b100:  alu_dec = 3'b100;
            3'b101:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b110;
            3'b111:  alu_dec = 3'b111;
            default: alu_dec = 3'b000;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (bus.funct3)
            3'b000:  branch_taken = bus.ZF;
            3'b001:  branch_taken = ~bus.ZF;
            3'b100:  branch_taken = bus.SF;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        mem_write      = 1'b0;
        bus.MemRead    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.ALUControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                bus.MemRead   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                ir_write      = bus.mem_ready;
                pc_write      = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = imm_dec;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = imm_dec;
                state_d     = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.MemRead = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write   = 1'b1;
                bus.AdrSrc  = 1'b1;
                bus.ImmSrc  = 2'b01;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b00;
                bus.ALUControl = alu_dec;
                state_d        = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_dec;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = 3'b010;
                pc_write       = branch_taken;
                state_d        = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // FETCH is the reset state and strobes on mem_ready, so reset must mask
    // the write enables directly rather than rely on the state register.
    assign bus.PCWrite  = pc_write  & rst_n;
    assign bus.IRWrite  = ir_write  & rst_n;
    assign bus.RegWrite = reg_write & rst_n;
    assign bus.MemWrite = mem_write & rst_n;
    assign bus.illegal  = (state_q == S_ILLEGAL);
    assign bus.state    = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-instruction state walks with
// hand-computed strobes, branch decisions, illegal trap and async reset.
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mc_ctrl_if bus();

    mc_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic test_reset();
        rst_n = 1'b0;
        bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7 = 1'b0;
        bus.ZF = 1'b0; bus.SF = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++;
        if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        checks++;
        if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=0000", {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       mr     [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = mr[i];
            #1;
            checks++;
            if (bus.state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state, exp_st[i]); end
            checks++;
            if (bus.RegWrite !== (exp_st[i] == 4'd4)) begin errors++; $display("FAIL lw_regwrite[%0d] got=%b", i, bus.RegWrite); end
            if (i == 0) begin
                checks++;
                if ({bus.MemRead, bus.IRWrite, bus.PCWrite, bus.ALUSrcB, bus.ResultSrc} !== 7'b111_10_10) begin
                    errors++;
                    $display("FAIL fetch_ctrl got=%b exp=1111010", {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.ALUSrcB, bus.ResultSrc});
                end
            end
            if (i == 3) begin
                checks++;
                if ({bus.MemRead, bus.AdrSrc, bus.PCWrite, bus.IRWrite} !== 4'b1100) begin
                    errors++;
                    $display("FAIL memread_ctrl got=%b exp=1100", {bus.MemRead, bus.AdrSrc, bus.PCWrite, bus.IRWrite});
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.ResultSrc !== 2'b01) begin errors++; $display("FAIL memwb_resultsrc got=%b exp=01", bus.ResultSrc); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        logic       mr     [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.op = 7'b0100011; bus.funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = mr[i];
            #1;
            checks++;
            if (bus.state !== exp_st[i]) begin errors++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, bus.state, exp_st[i]); end
            checks++;
            if (bus.MemWrite !== (exp_st[i] == 4'd5)) begin errors++; $display("FAIL sw_memwrite[%0d] got=%b", i, bus.MemWrite); end
            checks++;
            if (bus.MemWrite && bus.MemRead) begin errors++; $display("FAIL sw_rw_overlap[%0d] got=11 exp=not both", i); end
            if (i == 1 || i == 2 || i == 3) begin
                checks++;
                if (bus.ImmSrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc[%0d] got=%b exp=01", i, bus.ImmSrc); end
            end
            if (i == 3) begin
                checks++;
                if ({bus.AdrSrc, bus.RegWrite} !== 2'b10) begin errors++; $display("FAIL sw_adrsrc got=%b exp=10", {bus.AdrSrc, bus.RegWrite}); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] op_t  [4] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011};
        logic [2:0] f3_t  [4] = '{3'b000, 3'b000, 3'b100, 3'b010};
        logic       f7_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] ex_t  [4] = '{4'd6, 4'd7, 4'd6, 4'd7};
        logic [2:0] alu_t [4] = '{3'b010, 3'b000, 3'b100, 3'b000};
        logic [1:0] srcb_t[4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        for (int k = 0; k < 4; k++) begin
            bus.op = op_t[k]; bus.funct3 = f3_t[k]; bus.funct7 = f7_t[k];
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            @(negedge clk); #1;
            checks++;
            if (bus.state !== ex_t[k]) begin errors++; $display("FAIL alu_exec_state[%0d] got=%0d exp=%0d", k, bus.state, ex_t[k]); end
            checks++;
            if (bus.ALUControl !== alu_t[k]) begin errors++; $display("FAIL alu_ctrl[%0d] got=%b exp=%b", k, bus.ALUControl, alu_t[k]); end
            checks++;
            if ({bus.ALUSrcA, bus.ALUSrcB} !== {2'b10, srcb_t[k]}) begin
                errors++;
                $display("FAIL alu_srcs[%0d] got=%b exp=%b", k, {bus.ALUSrcA, bus.ALUSrcB}, {2'b10, srcb_t[k]});
            end
            @(negedge clk); #1;
            checks++;
            if ({bus.state, bus.RegWrite, bus.ResultSrc} !== {4'd8, 1'b1, 2'b00}) begin
                errors++;
                $display("FAIL aluwb[%0d] got=%b exp=1000100", k, {bus.state, bus.RegWrite, bus.ResultSrc});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3_t [5] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b000};
        logic       zf_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       sf_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       pc_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.op = 7'b1100011; bus.funct7 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.funct3 = f3_t[k]; bus.ZF = zf_t[k]; bus.SF = sf_t[k];
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.ImmSrc !== 2'b10) begin errors++; $display("FAIL br_decode_imm[%0d] got=%b exp=10", k, bus.ImmSrc); end
            @(negedge clk); #1;
            checks++;
            if (bus.state !== 4'd9) begin errors++; $display("FAIL br_state[%0d] got=%0d exp=9", k, bus.state); end
            checks++;
            if (bus.PCWrite !== pc_t[k]) begin errors++; $display("FAIL br_pcwrite[%0d] got=%b exp=%b", k, bus.PCWrite, pc_t[k]); end
            checks++;
            if (bus.ALUControl !== 3'b010) begin errors++; $display("FAIL br_aluctrl[%0d] got=%b exp=010", k, bus.ALUControl); end
            @(negedge clk); #1;
            checks++;
            if (bus.state !== 4'd0) begin errors++; $display("FAIL br_return[%0d] got=%0d exp=0", k, bus.state); end
        end
        bus.ZF = 1'b0; bus.SF = 1'b0;
    endtask

    task automatic test_illegal();
        bus.op = 7'b1111111; bus.funct3 = 3'b000;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.ZF = i[0];
            #1;
            checks++;
            if ({bus.state, bus.illegal} !== {4'd10, 1'b1}) begin
                errors++;
                $display("FAIL illegal_hold[%0d] got=%b exp=10101", i, {bus.state, bus.illegal});
            end
            checks++;
            if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.AdrSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl} !== 17'b0) begin
                errors++;
                $display("FAIL illegal_outputs[%0d] nonzero control output", i);
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.illegal} !== 5'b00000) begin
            errors++;
            $display("FAIL illegal_reset got=%b exp=00000", {bus.state, bus.illegal});
        end
        bus.mem_ready = 1'b0; bus.ZF = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        bus.op = 7'b0000011; bus.funct3 = 3'b010;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus.state !== 4'd3) begin errors++; $display("FAIL areset_pre got=%0d exp=3", bus.state); end
        #1 rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0) begin errors++; $display("FAIL areset_state got=%0d exp=0", bus.state); end
        checks++;
        if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_strobes got=%b exp=0000", {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
        end
        @(negedge clk); #1;
        checks++;
        if ({bus.state, bus.PCWrite, bus.IRWrite} !== 6'b0) begin
            errors++;
            $display("FAIL areset_held got=%b exp=000000", {bus.state, bus.PCWrite, bus.IRWrite});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.IRWrite} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL areset_release got=%b exp=00001", {bus.state, bus.IRWrite});
        end
        @(negedge clk); #1;
        checks++;
        if (bus.state !== 4'd1) begin errors++; $display("FAIL areset_first_edge got=%0d exp=1", bus.state); end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_lw();
        test_sw();
        test_alu_ops();
        test_branch();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
